// File: rtl/icache_miss_controller_if.sv
// Memory-side line-read bus of the I-cache miss controller.
// The master modport is the controller; the slave modport is the memory system.
interface icache_miss_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  logic                    memReq;
  logic [ADDR_WIDTH-1:0]   memReqAddr;
  logic                    memReqAck;
  logic                    memRspValid;
  logic [8*LINE_BYTES-1:0] memRspData;

  modport master (
    output memReq, memReqAddr,
    input  memReqAck, memRspValid, memRspData
  );

  modport slave (
    input  memReq, memReqAddr,
    output memReqAck, memRspValid, memRspData
  );
endinterface

// File: rtl/icache_miss_controller.sv
// I-cache miss controller: IDLE -> REQ -> WAIT -> FILL line refill sequencer.
// Optional miss counter enabled by defining RSD_ICACHE_MISS_COUNTER_EN.
module icache_miss_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    icRE,
  input  logic [ADDR_WIDTH-1:0]   icReadAddrIn,
  input  logic                    icMiss,
  input  logic                    flush,
  icache_miss_controller_if.master memBus,
  output logic                    fillWE,
  output logic [ADDR_WIDTH-1:0]   fillAddr,
  output logic [8*LINE_BYTES-1:0] fillData,
  output logic                    fetchStall,
  output logic                    busy,
  output logic [31:0]             missCount
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} stateT;

  stateT                   state;
  stateT                   nextState;
  logic                    memReqQ;
  logic                    missStart;
  logic [ADDR_WIDTH-1:0]   lineAddr;
  logic [8*LINE_BYTES-1:0] lineData;

  assign missStart = (state == IDLE) && icRE && icMiss && !flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (missStart)          nextState = REQ;
      REQ:  if (memBus.memReqAck)   nextState = WAIT;
      WAIT: if (memBus.memRspValid) nextState = FILL;
      FILL:                         nextState = IDLE;
      default:                      nextState = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fillWE     = 1'b0;
    busy       = 1'b1;
    fetchStall = 1'b1;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        fetchStall = missStart;
      end
      FILL:    fillWE = 1'b1;
      default: ;
    endcase
  end

  // memReq comes straight from a flop so the bus sees a glitch-free request.
  always_ff @(posedge clk) begin
    if (rst) memReqQ <= 1'b0;
    else     memReqQ <= (nextState == REQ);
  end

  // NOTE: the line buffer is a single register, not an array, so it is reset
  // along with the control state; no stale line can leak after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lineAddr <= '0;
      lineData <= '0;
    end else begin
      if (missStart) lineAddr <= icReadAddrIn & ~OFFSET_MASK;
      if (state == WAIT && memBus.memRspValid) lineData <= memBus.memRspData;
    end
  end

  assign memBus.memReq     = memReqQ;
  assign memBus.memReqAddr = lineAddr;
  assign fillAddr          = lineAddr;
  assign fillData          = lineData;

`ifdef RSD_ICACHE_MISS_COUNTER_EN
  logic [31:0] missCountQ;

  always_ff @(posedge clk) begin
    if (rst)            missCountQ <= '0;
    else if (missStart) missCountQ <= missCountQ + 32'd1;
  end

  assign missCount = missCountQ;
`else
  assign missCount = '0;
`endif

endmodule
